// File: rtl/tremolo_pkg.sv
// Shared constants and the FSM state type for the tremolo VCA.
package tremolo_pkg;

  localparam int MOD_W       = 9;   // unsigned LFO value width, midpoint 256
  localparam int DEPTH_W     = 8;   // effect depth width, 0 = bypass
  localparam int GAIN_MAX    = 511; // unity-ish gain (x511/512)
  localparam int VCA_LATENCY = 19;  // capture edge to data_o register edge
  localparam int ATT_CYCLES  = 8;   // one step per depth bit

  typedef enum logic [2:0] {
    IDLE,
    ATT,
    GAIN,
    MUL,
    OUT
  } vca_state_t;

endpackage

// File: rtl/serial_mult.sv
// Shift-add serial multiplier, one multiplier (b) bit per cycle, LSB first.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   start_i       load operands and clear the accumulator (wins over stepping)
//   a_i           multiplicand, signed when A_SIGNED=1
//   b_i           unsigned multiplier
//   done_o        high during the cycle whose closing edge adds the last bit
//   product_o     running accumulator; final once the step after done_o ends
module serial_mult #(
  parameter int AW       = 16,
  parameter int BW       = 9,
  parameter bit A_SIGNED = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    a_i,
  input  logic [BW-1:0]    b_i,
  output logic             done_o,
  output logic [AW+BW-1:0] product_o
);

  localparam int PW = AW + BW;
  localparam int SW = $clog2(BW);

  logic [PW-1:0] mcand_q;
  logic [BW-1:0] mplier_q;
  logic [PW-1:0] acc_q;
  logic [SW-1:0] step_q;
  logic          run_q;
  logic          a_ext;

  // The PW-bit accumulator is wide enough that modular addition of the
  // sign-extended multiplicand yields the exact signed product.
  assign a_ext = A_SIGNED ? a_i[AW-1] : 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      run_q    <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{BW{a_ext}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      step_q   <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      step_q   <= step_q + 1'b1;
      if (step_q == SW'(BW - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o    = run_q && (step_q == SW'(BW - 1));
  assign product_o = acc_q;

endmodule

// File: rtl/tremolo_vca.sv
// Tremolo VCA: applies a 9-bit LFO value as gain to a signed audio sample.
//   att  = (depth * (511 - mod)) >> 8
//   gain = 511 - att
//   out  = (data * gain) >>> 9, or data unchanged when depth == 0
// Both products share one serial multiplier.
// Ports:
//   clk_i, rst_i   system clock, asynchronous active-high reset
//   sample_tick_i  new sample strobe; accepted only in IDLE
//   data_i         signed sample
//   depth_i        effect depth
//   modulator_i    unsigned LFO value
//   data_o         modulated sample, held between valid_o strobes
//   valid_o        one-cycle strobe, data_o updated
//   busy_o         computation in flight
//   overrun_o      sticky, a tick arrived while busy
// Handshake: sample_tick_i is a fire-and-forget strobe with no ready; a tick
// seen while busy_o is high is dropped and recorded in overrun_o.
module tremolo_vca
  import tremolo_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sample_tick_i,
  input  logic [DW-1:0]      data_i,
  input  logic [DEPTH_W-1:0] depth_i,
  input  logic [MOD_W-1:0]   modulator_i,
  output logic [DW-1:0]      data_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               overrun_o
);

  localparam int PW = DW + MOD_W;

  vca_state_t         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [DW-1:0]      data_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [DW-1:0]      out_q;
  logic               valid_q;
  logic               overrun_q;

  logic               accept;
  logic               mult_start;
  logic [DW-1:0]      mult_a;
  logic [MOD_W-1:0]   mult_b;
  logic               mult_done;
  logic [PW-1:0]      product;
  logic [MOD_W-1:0]   inv_mod;
  logic [MOD_W-1:0]   att;
  logic [MOD_W-1:0]   gain;
  logic [DW-1:0]      out_d;
  logic               unused_bits;

  assign accept  = sample_tick_i && (state_q == IDLE);
  assign inv_mod = MOD_W'(GAIN_MAX) - modulator_i;
  // After the 8 ATT steps the product is depth*(511-mod) <= 17 bits.
  assign att     = product[DEPTH_W +: MOD_W];
  assign gain    = MOD_W'(GAIN_MAX) - att;
  assign out_d   = (depth_q == '0) ? data_q : product[PW-1:MOD_W];
  // Fraction bits below the attenuation field carry no information.
  assign unused_bits = ^product[DEPTH_W-1:0];

  // In IDLE the first multiply is fed straight from the ports so it can load
  // on the capture edge; afterwards the captured sample and gain are used.
  always_comb begin
    mult_a = data_q;
    mult_b = gain;
    if (state_q == IDLE) begin
      mult_a = {{(DW - MOD_W){1'b0}}, inv_mod};
      mult_b = {1'b0, depth_i};
    end
  end

  serial_mult #(
    .AW       (DW),
    .BW       (MOD_W),
    .A_SIGNED (1'b1)
  ) u_mult (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mult_start),
    .a_i       (mult_a),
    .b_i       (mult_b),
    .done_o    (mult_done),
    .product_o (product)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mult_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick_i) begin
          state_d    = ATT;
          cnt_d      = '0;
          mult_start = 1'b1;
        end
      end
      ATT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 3'(ATT_CYCLES - 1)) begin
          state_d = GAIN;
        end
      end
      GAIN: begin
        mult_start = 1'b1;
        state_d    = MUL;
      end
      MUL: begin
        if (mult_done) begin
          state_d = OUT;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      depth_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_q == OUT);
      if (accept) begin
        data_q  <= data_i;
        depth_q <= depth_i;
      end
      if (state_q == OUT) begin
        out_q <= out_d;
      end
      if (sample_tick_i && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign data_o    = out_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_tremolo_vca.sv
// Directed bench for tremolo_vca with hand-computed expected samples.
module tb_tremolo_vca;
  import tremolo_pkg::*;

  localparam int DW = 16;

  logic          clk_i;
  logic          rst_i;
  logic          sample_tick_i;
  logic [DW-1:0] data_i;
  logic [7:0]    depth_i;
  logic [8:0]    modulator_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          busy_o;
  logic          overrun_o;

  int checks;
  int errors;

  tremolo_vca #(.DW(DW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sample_tick_i (sample_tick_i),
    .data_i        (data_i),
    .depth_i       (depth_i),
    .modulator_i   (modulator_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  // clock / reset block
  initial clk_i = 1'b0;
  always #20 clk_i = ~clk_i;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called 1ns after an edge; the next edge is the capture edge N.
  // Returns 1ns after edge N with the tick dropped again.
  task automatic drive_tick(input int d, input int dp, input int m);
    data_i        = DW'(d);
    depth_i       = 8'(dp);
    modulator_i   = 9'(m);
    sample_tick_i = 1'b1;
    @(posedge clk_i);
    #1;
    sample_tick_i = 1'b0;
  endtask

  // Counts edges until valid_o is seen; returns 99 if it never appears.
  task automatic wait_valid(output int lat);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input int d, input int dp,
                         input int m, input int exp);
    int lat;
    drive_tick(d, dp, m);
    check({tag, "_busy"}, 32'(busy_o), 1);
    wait_valid(lat);
    check({tag, "_lat"}, lat, VCA_LATENCY);
    check({tag, "_data"}, $signed(data_o), exp);
    @(posedge clk_i);
    #1;
    check({tag, "_width"}, 32'(valid_o), 0);
  endtask

  initial begin
    int lat;
    int vcount;
    checks        = 0;
    errors        = 0;
    rst_i         = 1'b1;
    sample_tick_i = 1'b0;
    data_i        = '0;
    depth_i       = '0;
    modulator_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data", $signed(data_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ovr", 32'(overrun_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // gain arithmetic vectors
    run_vec("bypass", 16384, 0, 37, 16384);
    run_vec("mod511", 16384, 255, 511, 16352);
    run_vec("mod0", 16384, 255, 0, 64);
    run_vec("negmax", -32768, 128, 256, -24576);
    run_vec("floor", -1, 255, 0, -1);
    check("no_ovr", 32'(overrun_o), 0);

    // inputs changed right after capture must not matter
    drive_tick(8000, 200, 100);
    data_i      = DW'(-5);
    depth_i     = 8'd0;
    modulator_i = 9'd0;
    wait_valid(lat);
    check("cap_lat", lat, VCA_LATENCY);
    check("cap_data", $signed(data_o), 2968);
    @(posedge clk_i);
    #1;

    // second tick at N+10 is dropped and flags overrun
    drive_tick(1000, 255, 511);
    repeat (9) @(posedge clk_i);
    #1;
    drive_tick(5000, 0, 0);
    check("ovr_set", 32'(overrun_o), 1);
    wait_valid(lat);
    check("ovr_lat", lat, VCA_LATENCY - 10);
    check("ovr_data", $signed(data_o), 998);
    // tick at N+20 is accepted
    drive_tick(2000, 0, 0);
    check("n20_busy", 32'(busy_o), 1);
    check("n20_valid", 32'(valid_o), 0);
    wait_valid(lat);
    check("n20_lat", lat, VCA_LATENCY);
    check("n20_data", $signed(data_o), 2000);
    check("ovr_sticky", 32'(overrun_o), 1);
    @(posedge clk_i);
    #1;

    // reset at N+12 aborts the computation
    drive_tick(8000, 200, 100);
    repeat (12) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_data", $signed(data_o), 0);
    check("mid_rst_valid", 32'(valid_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_ovr", 32'(overrun_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    vcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    run_vec("post_rst", 8000, 200, 100, 2968);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
